vpu_ifetch: RTL and testbench
=============================

// Module: vpu_ifetch
// PURPOSE
//  Instruction fetch/issue front end for the VPU execute unit. Reads 32-bit instruction words
//  from a synchronous program memory, buffers them in a small FIFO and presents them as IR words
//  over a valid/ready handshake. Sits between program memory and the IR input of the execute stage.
//  Fetch stops on a HALT opcode in IR[31:27]; the HALT word itself is never issued.
// PARAMETERS
//  ADDR_W      8         program memory address width; PC wraps modulo 2**ADDR_W
//  FIFO_DEPTH  4         issue FIFO entries; power of two, >= 2
//  HALT_OP     5'b11111  opcode (IR[31:27]) that ends fetch
// PORTS
//  clk         in   1       clock, all state on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  start       in   1       begin fetch at start_pc; honoured only in IDLE, otherwise ignored
//  start_pc    in   ADDR_W  first fetch address, sampled with start
//  abort       in   1       synchronous flush: empty FIFO, squash in-flight read, return to IDLE
//  imem_en     out  1       program memory read strobe
//  imem_addr   out  ADDR_W  program memory read address
//  imem_rdata  in   32      read data, valid the cycle after imem_en (fixed 1-cycle latency)
//  ir          out  32      FIFO head instruction word
//  ir_valid    out  1       ir holds a valid instruction
//  ir_ready    in   1       execute unit accepts ir this cycle
//  busy        out  1       state != IDLE
//  done        out  1       one-cycle pulse: HALT reached and all fetched words issued
//  pc          out  ADDR_W  next address to be fetched
//  instr_count out  16      words issued (valid&&ready) since last accepted start; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, FIFO empty, in-flight flag 0, all outputs 0 (ir=0, pc=0).
//  States: IDLE -start-> FETCH -HALT returned-> DRAIN -FIFO empty-> DONE -> IDLE. abort: any -> IDLE.
//  IDLE: imem_en=0. On start: pc<=start_pc, instr_count<=0, FIFO cleared, -> FETCH.
//  FETCH: imem_en=1, imem_addr=pc, when (fifo_count + inflight) < FIFO_DEPTH, using the current-cycle
//   count (pop this cycle not credited); on issue pc<=pc+1 (wraps 2**ADDR_W-1 -> 0), inflight<=1.
//  Return (cycle after imem_en): if imem_rdata[31:27]==HALT_OP -> not pushed, -> DRAIN, no further reads;
//   else pushed to FIFO tail. A read issued in the same cycle the HALT returns is squashed on return.
//  DRAIN: imem_en=0; stays until FIFO empty (and no in-flight read), then -> DONE.
//  DONE: done=1 for exactly one cycle, -> IDLE. busy=1 in FETCH/DRAIN/DONE.
//  Issue: ir=FIFO head, ir_valid=!empty; pop on ir_valid&&ir_ready; ir stable while valid&&!ready.
//   Simultaneous push+pop allowed in any state, count unchanged. No overflow/underflow possible by
//   credit rule; push into full FIFO or pop from empty FIFO is a design error (assertion).
//  Latency: start at cycle 0 -> imem_en cycle 1 -> rdata cycle 2 -> ir_valid cycle 3.
//   Full throughput: one word per cycle with ir_ready held 1.
//  abort (priority over start and all other events): FIFO emptied, in-flight return dropped,
//   ir_valid=0 and imem_en=0 from next cycle, no done pulse, instr_count and pc retained.
//  Reset mid-operation: immediate return to reset state; in-flight data ignored.
// TESTING
//  T1 mem[10..13]={MOV,ADD,SUB,HALT}, start_pc=8'h10, ir_ready=1 -> ir_valid cycles 3..5 with
//     MOV,ADD,SUB in order; done pulse cycle 7; instr_count=3; HALT never on ir.
//  T2 10-word program + HALT, ir_ready=0 for 20 cycles -> exactly 4 reads, ir = word0 stable;
//     release -> all 10 words in order, no loss/duplication, done once.
//  T3 HALT at start_pc -> ir_valid never 1, done pulse cycle 4, instr_count=0, busy back to 0.
//  T4 start_pc=8'hFE, HALT at 8'h01 -> imem_addr FE,FF,00,01; 3 words issued in that order.
//  T5 abort with 2 words queued and 1 in flight -> ir_valid=0 next cycle, no done; new start
//     afterwards fetches cleanly from new start_pc. start while busy -> ignored.
//  T6 rst_n low mid-FETCH (asynchronously, between edges) -> all outputs 0 immediately; normal T1 after release.

Source files
------------

// File: rtl/vpu_ifetch_if.sv
// Fetch-side bus bundle: program-memory read port plus the IR issue handshake.
interface vpu_ifetch_if #(
   parameter int ADDR_W = 8
);
   logic              imem_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic [31:0]       ir;
   logic              ir_valid;
   logic              ir_ready;

   modport master (
      output imem_en, imem_addr, ir, ir_valid,
      input  imem_rdata, ir_ready
   );

   modport slave (
      input  imem_en, imem_addr, ir, ir_valid,
      output imem_rdata, ir_ready
   );
endinterface

// File: rtl/vpu_ifetch.sv
// Instruction fetch/issue front end: reads program memory into a small FIFO and issues IR words
// until a HALT opcode returns.
//
// state   | meaning
// S_IDLE  | waiting for start, no reads
// S_FETCH | issuing reads while FIFO credit allows
// S_DRAIN | HALT seen, waiting for FIFO to empty
// S_DONE  | one-cycle done pulse, then back to idle
module vpu_ifetch #(
   parameter int       ADDR_W     = 8,
   parameter int       FIFO_DEPTH = 4,
   parameter logic [4:0] HALT_OP  = 5'b11111
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] start_pc_i,
   input  logic              abort_i,
   vpu_ifetch_if.master      bus,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic [15:0]       instr_count_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SUM_W = CNT_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              inflight_q, inflight_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       icnt_q, icnt_d;

   logic fifo_empty, fifo_full, credit_ok;
   logic start_ok, issue, halt_ret, push, pop;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
   // Credit uses this cycle's occupancy; a pop in the same cycle does not free a slot yet.
   assign credit_ok  = ({1'b0, count_q} + SUM_W'(inflight_q)) < SUM_W'(FIFO_DEPTH);
   assign start_ok   = (state_q == S_IDLE) && start_i && !abort_i;
   assign issue      = (state_q == S_FETCH) && credit_ok;
   assign halt_ret   = inflight_q && (bus.imem_rdata[31:27] == HALT_OP);
   assign push       = inflight_q && !halt_ret && !abort_i;
   assign pop        = !fifo_empty && bus.ir_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         inflight_q <= 1'b0;
         pc_q       <= '0;
         icnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         pc_q       <= pc_d;
         icnt_q     <= icnt_d;
      end
   end

   // Storage needs no reset: ir is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= bus.imem_rdata;
   end

   always_comb begin
      state_d = state_q;
      if (abort_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (start_i) state_d = S_FETCH;
            S_FETCH: if (halt_ret) state_d = S_DRAIN;
            S_DRAIN: if (fifo_empty && !inflight_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      inflight_d = inflight_q;
      pc_d       = pc_q;
      icnt_d     = icnt_q;
      if (pop && (icnt_q != 16'hFFFF)) icnt_d = icnt_q + 16'd1;
      if (abort_i || start_ok) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         inflight_d = 1'b0;
         if (start_ok) begin
            pc_d   = start_pc_i;
            icnt_d = '0;
         end
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         // A read launched alongside a returning HALT is dropped by never marking it in flight.
         inflight_d = issue && !halt_ret;
         if (issue) pc_d = pc_q + ADDR_W'(1);
      end
   end

   assign bus.imem_en   = issue;
   assign bus.imem_addr = pc_q;
   assign bus.ir_valid  = !fifo_empty;
   assign bus.ir        = fifo_empty ? 32'd0 : fifo_q[rd_ptr_q];
   assign busy_o        = (state_q != S_IDLE);
   assign done_o        = (state_q == S_DONE);
   assign pc_o          = pc_q;
   assign instr_count_o = icnt_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && fifo_full && !pop));
   a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
      count_q <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_vpu_ifetch.sv
// Bench for vpu_ifetch: directed timing scenarios plus random programs checked against an
// expected-word queue derived from the memory image.
module tb_vpu_ifetch;
   localparam int         AW   = 8;
   localparam logic [4:0] HALT = 5'b11111;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] start_pc = '0;
   logic          busy, done;
   logic [AW-1:0] pc;
   logic [15:0]   icnt;

   vpu_ifetch_if #(.ADDR_W(AW)) bus ();

   vpu_ifetch #(.ADDR_W(AW), .FIFO_DEPTH(4), .HALT_OP(HALT)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start),
      .start_pc_i    (start_pc),
      .abort_i       (abort),
      .bus           (bus.master),
      .busy_o        (busy),
      .done_o        (done),
      .pc_o          (pc),
      .instr_count_o (icnt)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [256];
   always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];

   int n_chk = 0;
   int n_fail = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if (w[31:27] == HALT) w[31] = 1'b0;
      return w;
   endfunction

   task automatic fill_mem();
      for (int i = 0; i < 256; i++) mem[i] = rand_word();
   endtask

   int            first_valid, done_cyc, n_done, reads_at_hold, n_valid;
   logic [AW-1:0] addr_q[$];
   logic [31:0]   exp_q[$];

   // Runs one program from spc; the expected issue stream is every word up to the first HALT.
   task automatic run_prog(input logic [AW-1:0] spc, input int hold, input int rdy_pct,
                           input int stray);
      logic [AW-1:0] a;
      int cyc, n_exp;
      bit finished;
      exp_q.delete();
      addr_q.delete();
      a = spc;
      for (int k = 0; k < 256 && mem[a][31:27] != HALT; k++) begin
         exp_q.push_back(mem[a]);
         a = a + 8'd1;
      end
      n_exp = exp_q.size();
      first_valid = -1; done_cyc = -1; n_done = 0; reads_at_hold = 0; n_valid = 0;
      @(negedge clk);
      start = 1'b1; start_pc = spc; bus.ir_ready = 1'b0;
      cyc = 0; finished = 0;
      while (!finished && cyc < 400) begin
         @(negedge clk);
         cyc++;
         start = (cyc == stray);
         if (cyc == stray) start_pc = spc ^ 8'h55;
         bus.ir_ready = (cyc <= hold) ? 1'b0 : ($urandom_range(99) < rdy_pct);
         if (bus.imem_en) addr_q.push_back(bus.imem_addr);
         if (cyc == hold) reads_at_hold = addr_q.size();
         if (bus.ir_valid) begin
            n_valid++;
            if (first_valid < 0) first_valid = cyc;
            if (exp_q.size() == 0) check_val("extra_word", 32'd1, 32'd0);
            else begin
               check_val("ir_word", bus.ir, exp_q[0]);
               if (bus.ir_ready) void'(exp_q.pop_front());
            end
         end
         if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (n_done > 0 && !done) finished = 1;
      end
      start = 1'b0;
      bus.ir_ready = 1'b0;
      check_val("run_timeout", 32'(finished), 32'd1);
      check_val("words_left", 32'(exp_q.size()), 32'd0);
      check_val("done_once", 32'(n_done), 32'd1);
      check_val("instr_count", 32'(icnt), 32'(n_exp));
      check_val("busy_end", 32'(busy), 32'd0);
   endtask

   task automatic load_t1();
      fill_mem();
      mem[8'h10] = 32'h0800_0001;
      mem[8'h11] = 32'h1000_0002;
      mem[8'h12] = 32'h1800_0003;
      mem[8'h13] = {HALT, 27'd0};
   endtask

   task automatic check_t1();
      run_prog(8'h10, 0, 100, 0);
      check_val("t1_first_valid", 32'(first_valid), 32'd3);
      check_val("t1_valid_cycles", 32'(n_valid), 32'd3);
      check_val("t1_done_cyc", 32'(done_cyc), 32'd7);
   endtask

   initial begin
      bus.ir_ready = 1'b0;
      fill_mem();
      repeat (3) @(negedge clk);
      check_val("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
      check_val("rst_imem_en", 32'(bus.imem_en), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_pc", 32'(pc), 32'd0);
      check_val("rst_icnt", 32'(icnt), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // T1: short program, full throughput
      load_t1();
      check_t1();

      // T2: ten words, consumer stalled for 20 cycles
      fill_mem();
      mem[8'h4A] = {HALT, 27'd0};
      run_prog(8'h40, 20, 100, 0);
      check_val("t2_reads_stalled", 32'(reads_at_hold), 32'd4);

      // T3: HALT at the start address
      fill_mem();
      mem[8'h30] = {HALT, 27'd0};
      run_prog(8'h30, 0, 100, 0);
      check_val("t3_no_valid", 32'(first_valid), 32'hFFFF_FFFF);
      check_val("t3_done_cyc", 32'(done_cyc), 32'd4);

      // T4: address wrap
      fill_mem();
      mem[8'h01] = {HALT, 27'd0};
      run_prog(8'hFE, 0, 100, 0);
      check_val("t4_nreads", 32'(addr_q.size() >= 4), 32'd1);
      if (addr_q.size() >= 4) begin
         check_val("t4_addr0", 32'(addr_q[0]), 32'h0FE);
         check_val("t4_addr1", 32'(addr_q[1]), 32'h0FF);
         check_val("t4_addr2", 32'(addr_q[2]), 32'h000);
         check_val("t4_addr3", 32'(addr_q[3]), 32'h001);
      end

      // T5: abort with two words queued and one read in flight
      fill_mem();
      mem[8'h6A] = {HALT, 27'd0};
      @(negedge clk);
      start = 1'b1; start_pc = 8'h60; bus.ir_ready = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 4) begin
            check_val("t5_pre_valid", 32'(bus.ir_valid), 32'd1);
            abort = 1'b1;
         end
      end
      @(negedge clk);
      abort = 1'b0;
      check_val("t5_ir_valid", 32'(bus.ir_valid), 32'd0);
      check_val("t5_imem_en", 32'(bus.imem_en), 32'd0);
      check_val("t5_busy", 32'(busy), 32'd0);
      n_done = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done || bus.ir_valid) n_done++;
      end
      check_val("t5_quiet", 32'(n_done), 32'd0);
      fill_mem();
      mem[8'h97] = {HALT, 27'd0};
      run_prog(8'h90, 0, 70, 3);

      // T6: asynchronous reset mid-fetch, then a clean T1
      load_t1();
      @(negedge clk);
      start = 1'b1; start_pc = 8'h10; bus.ir_ready = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_val("t6_ir_valid", 32'(bus.ir_valid), 32'd0);
      check_val("t6_ir", bus.ir, 32'd0);
      check_val("t6_imem_en", 32'(bus.imem_en), 32'd0);
      check_val("t6_busy", 32'(busy), 32'd0);
      check_val("t6_pc", 32'(pc), 32'd0);
      check_val("t6_icnt", 32'(icnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.ir_ready = 1'b0;
      @(negedge clk);
      check_t1();

      // Random programs with random consumer back-pressure
      for (int it = 0; it < 10; it++) begin
         logic [AW-1:0] spc;
         int len;
         fill_mem();
         spc = AW'($urandom_range(255));
         len = $urandom_range(12);
         mem[spc + AW'(len)] = {HALT, 27'(len)};
         run_prog(spc, $urandom_range(8), $urandom_range(100, 20), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
